stopwatch_controller: RTL



---
 rtl/stopwatch_controller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/stopwatch_controller.sv
// Stopwatch run-control sequencer: button edge detection, run/pause/lap FSM,
// gated count enable, registered clear pulse and lap-freeze display register.
module stopwatch_controller #(
  parameter int unsigned NUMBER_OF_DIGITS = 4,
  parameter int unsigned STOP_AT_MAX      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          start_stop,
  input  logic                          lap,
  input  logic                          clear,
  input  logic                          at_max,
  input  logic [4*NUMBER_OF_DIGITS-1:0] live_number,
  output logic                          count_en,
  output logic                          count_clr,
  output logic [4*NUMBER_OF_DIGITS-1:0] display_number,
  output logic [1:0]                    state,
  output logic                          running,
  output logic                          lap_active
);

  localparam int unsigned W = 4 * NUMBER_OF_DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP     = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           ss_prev_q, lap_prev_q, clr_prev_q;
  logic           count_clr_q, count_clr_d;
  logic           running_q, lap_active_q;
  logic [W-1:0]   display_q, display_d;

  logic           ev_ss, ev_lap, ev_clr, ev_any;
  logic           act_ss, act_lap, act_clr;
  logic           active, sat, sat_move;

  // Rising-edge events, single-winner priority, enable gating and next state.
  always_comb begin
    ev_ss       = start_stop & ~ss_prev_q;
    ev_lap      = lap & ~lap_prev_q;
    ev_clr      = clear & ~clr_prev_q;
    ev_any      = ev_ss | ev_lap | ev_clr;
    // Highest-priority event wins the cycle; the rest are dropped.
    act_clr     = ev_clr;
    act_ss      = ev_ss & ~ev_clr;
    act_lap     = ev_lap & ~ev_clr & ~ev_ss;

    active      = (state_q == RUNNING) || (state_q == LAP);
    sat         = (STOP_AT_MAX != 0) & at_max;
    count_en    = tick & active & ~sat;
    // Saturation pause yields to any button event in the same cycle.
    sat_move    = tick & sat & ~ev_any;

    state_d     = state_q;
    count_clr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (act_clr) begin
          count_clr_d = 1'b1;
        end else if (act_ss) begin
          state_d = RUNNING;
        end
      end
      RUNNING: begin
        if (act_ss) begin
          state_d = PAUSED;
        end else if (act_lap) begin
          state_d = LAP;
        end else if (sat_move) begin
          state_d = PAUSED;
        end
      end
      LAP: begin
        if (act_ss) begin
          state_d = PAUSED;
        end else if (act_lap) begin
          state_d = RUNNING;
        end else if (sat_move) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (act_clr) begin
          state_d     = IDLE;
          count_clr_d = 1'b1;
        end else if (act_ss) begin
          state_d = RUNNING;
        end
      end
      default: state_d = IDLE;
    endcase

    // Hold the frozen value while staying in LAP; entering LAP captures live.
    if ((state_d == LAP) && (state_q == LAP)) begin
      display_d = display_q;
    end else begin
      display_d = live_number;
    end
  end

  // State, button history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ss_prev_q    <= 1'b1;
      lap_prev_q   <= 1'b1;
      clr_prev_q   <= 1'b1;
      count_clr_q  <= 1'b0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      display_q    <= '0;
    end else begin
      state_q      <= state_d;
      ss_prev_q    <= start_stop;
      lap_prev_q   <= lap;
      clr_prev_q   <= clear;
      count_clr_q  <= count_clr_d;
      running_q    <= (state_d == RUNNING) || (state_d == LAP);
      lap_active_q <= (state_d == LAP);
      display_q    <= display_d;
    end
  end

  assign count_clr      = count_clr_q;
  assign display_number = display_q;
  assign state          = state_q;
  assign running        = running_q;
  assign lap_active     = lap_active_q;

endmodule
